// File: rtl/addsub_iterative.sv
// addsub_iterative: multi-cycle adder/subtractor that handles CHUNK bits per clock.
// The carry is registered between chunks, so a wide word shares one narrow adder.
// There are valid/ready handshakes on both sides, and only one operation is in flight at a time.
// Optional feature macro: ADDSUB_OVERFLOW_EN. When it is defined, a signed overflow flag is produced.
// When it is undefined, the overflow port is tied to 0.
module addsub_iterative #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             carry_out_q, carry_out_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic             last_chunk;
  logic             accept;
  logic             finish;

  // State and datapath registers; reset discards any operation in flight and clears the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
    end
  end

  // Next-state logic: accept in IDLE, step through the chunks in CALC, wait for the consumer in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)     state_d = CALC;
      CALC:    if (last_chunk) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded directly from the state
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Chunk adder: pick the current chunk of each operand and add it with the registered carry
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    last_chunk = (cnt_q == CW'(N - 1));
    accept     = (state_q == IDLE) && in_valid;
    finish     = (state_q == CALC) && last_chunk;
  end

  // Datapath updates: latch operands on accept (B pre-inverted for subtract), accumulate chunks,
  // and publish the result only when the final chunk completes
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    if (accept) begin
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = carry_in;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      for (int i = 0; i < N; i++) begin
        if (cnt_q == CW'(i)) begin
          acc_d[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
        end
      end
      carry_d = chunk_sum[CHUNK];
      cnt_d   = last_chunk ? '0 : cnt_q + CW'(1);
      if (finish) begin
        sum_d       = acc_d;
        carry_out_d = chunk_sum[CHUNK];
      end
    end
  end

  assign sum       = sum_q;
  assign carry_out = carry_out_q;

`ifdef ADDSUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
  logic msb_carry;

  // Signed overflow: the carry into the MSB differs from the carry out of it, sampled with the sum
  always_comb begin
    msb_carry = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    ovf_d     = finish ? (msb_carry ^ chunk_sum[CHUNK]) : ovf_q;
  end

  // Overflow flag register, cleared by reset alongside the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_addsub_iterative.sv
// Testbench for addsub_iterative: directed corner cases followed by randomized operations.
// The 32/8 instance is checked against a whole-word arithmetic reference model.
// A 16/16 instance checks single-cycle operation.
module tb_addsub_iterative;

  localparam int W0 = 32;
  localparam int C0 = 8;
  localparam int N0 = W0 / C0;
  localparam int W1 = 16;
  localparam int C1 = 16;

  logic clk = 1'b0;
  logic rst_n;

  // Chunked instance (32-bit, 8 bits per cycle)
  logic          in_valid, in_ready, carry_in, sub;
  logic          out_valid, out_ready, carry_out, overflow;
  logic [W0-1:0] a, b, sum;

  // Single-chunk instance (16-bit, one cycle)
  logic          in_valid_w, in_ready_w, carry_in_w, sub_w;
  logic          out_valid_w, out_ready_w, carry_out_w, overflow_w;
  logic [W1-1:0] a_w, b_w, sum_w;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_sum;
  logic        last_co;
  logic        last_ovf;

  always #5 clk = ~clk;

  addsub_iterative #(.WIDTH(W0), .CHUNK(C0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  addsub_iterative #(.WIDTH(W1), .CHUNK(C1)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .carry_in(carry_in_w), .sub(sub_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .sum(sum_w), .carry_out(carry_out_w), .overflow(overflow_w)
  );

  // Whole-word reference: returns {ovf, carry_out, sum[31:0]} for a w-bit operation
  function automatic logic [33:0] refModel(int w, logic [31:0] x, logic [31:0] y,
                                           logic ci, logic s);
    logic [63:0] mask, xm, bm, full;
    logic        sa, sb, ss, ovf;
    mask = (64'd1 << w) - 64'd1;
    xm   = {32'd0, x} & mask;
    bm   = s ? (~{32'd0, y} & mask) : ({32'd0, y} & mask);
    full = xm + bm + {63'd0, ci};
    sa   = xm[w-1];
    sb   = bm[w-1];
    ss   = full[w-1];
    ovf  = (sa == sb) && (ss != sa);
`ifndef ADDSUB_OVERFLOW_EN
    ovf = 1'b0;
`endif
    return {ovf, full[w], full[31:0] & mask[31:0]};
  endfunction

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full operation on the chunked instance: accept, latency, result, hold in DONE, release
  task automatic applyStimulus(logic [31:0] x, logic [31:0] y, logic ci, logic s,
                               int hold, logic early_ready);
    logic [33:0] r;
    int          cyc;
    r = refModel(W0, x, y, ci, s);
    @(negedge clk);
    a = x; b = y; carry_in = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'($urandom_range(0, 1));
    a         = $urandom;
    b         = $urandom;
    carry_in  = 1'($urandom_range(0, 1));
    sub       = 1'($urandom_range(0, 1));
    out_ready = early_ready;
    checkOutput("in_ready_calc", {63'd0, in_ready}, 64'd0);
    checkOutput("sum_retained", {32'd0, sum}, {32'd0, last_sum});
    checkOutput("co_retained", {63'd0, carry_out}, {63'd0, last_co});
    checkOutput("ovf_retained", {63'd0, overflow}, {63'd0, last_ovf});
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    checkOutput("latency", 64'(cyc), 64'(N0));
    checkOutput("sum", {32'd0, sum}, {32'd0, r[31:0]});
    checkOutput("carry_out", {63'd0, carry_out}, {63'd0, r[32]});
    checkOutput("overflow", {63'd0, overflow}, {63'd0, r[33]});
    in_valid = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", {63'd0, out_valid}, 64'd1);
      checkOutput("hold_sum", {32'd0, sum}, {32'd0, r[31:0]});
      checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("released_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("released_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("idle_sum", {32'd0, sum}, {32'd0, r[31:0]});
    last_sum = r[31:0];
    last_co  = r[32];
    last_ovf = r[33];
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [33:0] r;
    logic        seen_valid;
    logic [15:0] xw, yw;
    logic        ciw, sw;

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    in_valid_w = 1'b0; a_w = '0; b_w = '0; carry_in_w = 1'b0; sub_w = 1'b0; out_ready_w = 1'b0;
    last_sum = '0; last_co = 1'b0; last_ovf = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("reset_sum", {32'd0, sum}, 64'd0);
    checkOutput("reset_co", {63'd0, carry_out}, 64'd0);
    checkOutput("reset_ovf", {63'd0, overflow}, 64'd0);

    // Directed corner cases
    $display("[TB] directed operations");
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b0);
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0, 1'b1);
    applyStimulus(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 5, 1'b0);

    // Randomized operations
    $display("[TB] random operations");
    for (int i = 0; i < 30; i++) begin
      applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset two cycles after accept: nothing may be emitted
    $display("[TB] reset during calculation");
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h1111_1111; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("midreset_sum", {32'd0, sum}, 64'd0);
    checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    checkOutput("midreset_co", {63'd0, carry_out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    checkOutput("midreset_no_result", {63'd0, seen_valid}, 64'd0);
    last_sum = '0; last_co = 1'b0; last_ovf = 1'b0;
    applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);

    // Single-chunk instance: result one cycle after accept
    $display("[TB] single-chunk instance");
    for (int i = 0; i < 10; i++) begin
      if (i == 0) begin
        xw = 16'hFFFF; yw = 16'h0001; ciw = 1'b0; sw = 1'b0;
      end else if (i == 1) begin
        xw = 16'h7FFF; yw = 16'h0001; ciw = 1'b0; sw = 1'b0;
      end else begin
        xw = 16'($urandom); yw = 16'($urandom);
        ciw = 1'($urandom_range(0, 1)); sw = 1'($urandom_range(0, 1));
      end
      r = refModel(W1, {16'd0, xw}, {16'd0, yw}, ciw, sw);
      @(negedge clk);
      a_w = xw; b_w = yw; carry_in_w = ciw; sub_w = sw; in_valid_w = 1'b1;
      @(posedge clk); #1;
      in_valid_w = 1'b0;
      checkOutput("w16_in_ready_busy", {63'd0, in_ready_w}, 64'd0);
      @(posedge clk); #1;
      checkOutput("w16_latency", {63'd0, out_valid_w}, 64'd1);
      checkOutput("w16_sum", {48'd0, sum_w}, {48'd0, r[15:0]});
      checkOutput("w16_carry_out", {63'd0, carry_out_w}, {63'd0, r[32]});
      checkOutput("w16_overflow", {63'd0, overflow_w}, {63'd0, r[33]});
      @(negedge clk);
      out_ready_w = 1'b1;
      @(posedge clk); #1;
      out_ready_w = 1'b0;
      checkOutput("w16_in_ready", {63'd0, in_ready_w}, 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
